// File: rtl/nn_inference_sequencer_if.sv
// Handshake and status bundle between the inference front end and its neighbours.
// The slave modport is the sequencer's view; master is the driving side.
interface nn_inference_sequencer_if #(
  parameter int N             = 16,
  parameter int NUM_OF_INPUTS = 2
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         in_last;
  logic [N-1:0] vec_out [0:NUM_OF_INPUTS-1];
  logic         fire;
  logic         layer_done;
  logic [N-1:0] layer_data;
  logic         res_valid;
  logic         res_ready;
  logic [N-1:0] res_data;
  logic         res_class;
  logic         busy;
  logic         err_clr;
  logic         err_len;
  logic         err_timeout;

  modport slave (
    input  in_valid, in_data, in_last, layer_done, layer_data, res_ready, err_clr,
    output in_ready, vec_out, fire, res_valid, res_data, res_class, busy, err_len, err_timeout
  );

  modport master (
    output in_valid, in_data, in_last, layer_done, layer_data, res_ready, err_clr,
    input  in_ready, vec_out, fire, res_valid, res_data, res_class, busy, err_len, err_timeout
  );
endinterface

// File: rtl/nn_inference_sequencer.sv
// Frames a serial word stream into one input vector, fires the layer, waits for its
// result under a timeout and hands the result plus a class bit downstream.
module nn_inference_sequencer #(
  parameter int N             = 16,
  parameter int Q             = 13,
  parameter int NUM_OF_INPUTS = 2,
  parameter int TIMEOUT       = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  nn_inference_sequencer_if.slave    bus
);
  localparam int IDX_W = (NUM_OF_INPUTS > 1) ? $clog2(NUM_OF_INPUTS) : 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_OF_INPUTS - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic signed [N-1:0] THRESH = {{(N-Q){1'b0}}, 1'b1, {(Q-1){1'b0}}};

  typedef enum logic [2:0] {S_FILL, S_DRAIN, S_FIRE, S_WAIT, S_OUT} state_t;

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_idx, w_idx_nxt;
  logic [TMR_W-1:0] r_timer, w_timer_nxt;
  logic [N-1:0]     r_vec [0:NUM_OF_INPUTS-1];
  logic [N-1:0]     r_res_data;
  logic             r_res_class;
  logic             r_err_len, r_err_to;
  logic             w_accept, w_write, w_capture, w_set_len, w_set_to;

  assign bus.in_ready    = !rst && (r_state == S_FILL || r_state == S_DRAIN);
  assign bus.fire        = (r_state == S_FIRE);
  assign bus.res_valid   = (r_state == S_OUT);
  assign bus.busy        = (r_state != S_FILL);
  assign bus.res_data    = r_res_data;
  assign bus.res_class   = r_res_class;
  assign bus.err_len     = r_err_len;
  assign bus.err_timeout = r_err_to;

  for (genvar g = 0; g < NUM_OF_INPUTS; g++) begin : g_vec
    assign bus.vec_out[g] = r_vec[g];
  end

  assign w_accept = bus.in_valid && bus.in_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_timer_nxt = r_timer;
    w_write     = 1'b0;
    w_capture   = 1'b0;
    w_set_len   = 1'b0;
    w_set_to    = 1'b0;
    case (r_state)
      S_FILL: if (w_accept) begin
        w_write = 1'b1;
        if (r_idx == IDX_LAST) begin
          w_idx_nxt = '0;
          if (bus.in_last) w_state_nxt = S_FIRE;
          else begin
            w_set_len   = 1'b1;
            w_state_nxt = S_DRAIN;
          end
        end else if (bus.in_last) begin
          w_set_len = 1'b1;
          w_idx_nxt = '0;
        end else begin
          w_idx_nxt = r_idx + IDX_W'(1);
        end
      end
      // Overlong vector: swallow the tail up to and including its last word.
      S_DRAIN: if (w_accept && bus.in_last) w_state_nxt = S_FILL;
      S_FIRE: begin
        w_timer_nxt = '0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_timer_nxt = r_timer + TMR_W'(1);
        if (bus.layer_done) begin
          w_capture   = 1'b1;
          w_state_nxt = S_OUT;
        end else if (r_timer == TMR_LAST) begin
          w_set_to    = 1'b1;
          w_state_nxt = S_FILL;
        end
      end
      S_OUT: if (bus.res_ready) w_state_nxt = S_FILL;
      default: w_state_nxt = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_FILL;
      r_idx       <= '0;
      r_timer     <= '0;
      r_res_data  <= '0;
      r_res_class <= 1'b0;
      r_err_len   <= 1'b0;
      r_err_to    <= 1'b0;
      for (int i = 0; i < NUM_OF_INPUTS; i++) r_vec[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_timer <= w_timer_nxt;
      if (w_write) r_vec[r_idx] <= bus.in_data;
      if (w_capture) begin
        r_res_data  <= bus.layer_data;
        r_res_class <= ($signed(bus.layer_data) >= THRESH);
      end
      // A new error in the same cycle as a clear must survive.
      r_err_len <= w_set_len | (r_err_len & ~bus.err_clr);
      r_err_to  <= w_set_to  | (r_err_to  & ~bus.err_clr);
    end
  end
endmodule

// File: tb/tb_nn_inference_sequencer.sv
// Directed scenarios plus randomized frames against a transaction-level model of
// framing, fire/response timing, timeout and result classification.
module tb_nn_inference_sequencer;
  localparam int N = 16, Q = 13, NUM = 2, TIMEOUT = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nn_inference_sequencer_if #(.N(N), .NUM_OF_INPUTS(NUM)) bus ();

  nn_inference_sequencer #(.N(N), .Q(Q), .NUM_OF_INPUTS(NUM), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int total = 0, bad = 0;
  int fire_cnt = 0;
  int rsp_dly = -1;
  logic [N-1:0] rsp_data = '0;
  logic [N-1:0] snap [0:NUM-1];
  logic [N-1:0] q_w [$];
  logic prev_fire = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic exp_class(input logic [N-1:0] d);
    return int'($signed(d)) >= (1 << (Q-1));
  endfunction

  // Layer model: answers each fire rsp_dly cycles later (never when negative).
  initial begin
    bus.layer_done = 1'b0;
    bus.layer_data = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.fire) begin
        fire_cnt++;
        for (int j = 0; j < NUM; j++) snap[j] = bus.vec_out[j];
        if (rsp_dly > 0) begin
          repeat (rsp_dly) begin @(posedge clk); #1; end
          bus.layer_done = 1'b1;
          bus.layer_data = rsp_data;
          if (bus.busy)
            for (int j = 0; j < NUM; j++) chk("vec_stable", bus.vec_out[j], snap[j]);
          @(posedge clk); #1;
          bus.layer_done = 1'b0;
          bus.layer_data = $urandom_range(0, 65535);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (bus.fire) chk("fire_width", prev_fire, 1'b0);
    prev_fire <= bus.fire;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got running want finished");
    $fatal(1);
  end

  task automatic send_words();
    int w;
    for (int i = 0; i < q_w.size(); i++) begin
      bus.in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
      bus.in_valid = 1'b1;
      bus.in_data  = q_w[i];
      bus.in_last  = (i == q_w.size() - 1);
      w = 0;
      while (!bus.in_ready && w < 50) begin tick(); w++; end
      if (w >= 50) chk("in_ready_wait", 0, 1);
      tick();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;
  endtask

  task automatic run_frame(input int dly, input int hold, input logic [N-1:0] ld);
    int n, cnt, f0;
    logic exp_fire, seen_rv;
    n = q_w.size();
    exp_fire = (n == NUM);
    bus.err_clr = 1'b1; tick(); bus.err_clr = 1'b0;
    chk("clr_len", bus.err_len, 0);
    chk("clr_to", bus.err_timeout, 0);
    rsp_dly = dly;
    rsp_data = ld;
    f0 = fire_cnt;
    send_words();
    chk("fire_lat", bus.fire, exp_fire);
    chk("err_len", bus.err_len, !exp_fire);
    if (exp_fire) begin
      for (int j = 0; j < NUM; j++) chk("vec_out", bus.vec_out[j], q_w[j]);
      if (dly >= 1 && dly <= TIMEOUT) begin
        cnt = 0;
        while (!bus.res_valid && cnt < TIMEOUT + 20) begin tick(); cnt++; end
        chk("res_lat", cnt, dly + 1);
        chk("res_data", bus.res_data, ld);
        chk("res_class", bus.res_class, exp_class(ld));
        chk("no_to", bus.err_timeout, 0);
        for (int h = 0; h < hold; h++) begin
          tick();
          chk("hold_valid", bus.res_valid, 1);
          chk("hold_data", bus.res_data, ld);
          chk("hold_ready", bus.in_ready, 0);
        end
        bus.res_ready = 1'b1; tick(); bus.res_ready = 1'b0;
        chk("res_drop", bus.res_valid, 0);
        chk("back_fill", bus.in_ready, 1);
      end else begin
        cnt = 0;
        seen_rv = 1'b0;
        while (!bus.err_timeout && cnt < TIMEOUT + 20) begin
          tick(); cnt++; seen_rv |= bus.res_valid;
        end
        chk("to_lat", cnt, TIMEOUT + 1);
        chk("to_nores", seen_rv, 0);
        chk("to_ready", bus.in_ready, 1);
      end
    end else begin
      repeat (3) tick();
      chk("no_busy", bus.busy, 0);
    end
    chk("fire_cnt", fire_cnt - f0, exp_fire);
    q_w.delete();
  endtask

  initial begin
    int kind, n, r, dly, hold;
    logic [N-1:0] ld;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
    bus.res_ready = 1'b0; bus.err_clr = 1'b0;
    repeat (2) tick();
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_fire", bus.fire, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_res_data", bus.res_data, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_errs", {bus.err_len, bus.err_timeout}, 0);
    chk("rst_vec0", bus.vec_out[0], 0);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", bus.in_ready, 1);

    q_w = '{16'h2000, 16'hE000}; run_frame(5, 0, 16'h1800);
    q_w = '{16'h2000, 16'hE000}; run_frame(5, 10, 16'h0FFF);
    q_w = '{16'h1234};           run_frame(3, 0, 16'h0);
    q_w = '{16'h0AAA, 16'h0BBB}; run_frame(3, 0, 16'h1000);
    q_w = '{16'h1, 16'h2, 16'h3}; run_frame(3, 0, 16'h0);
    bus.err_clr = 1'b1; tick(); bus.err_clr = 1'b0;
    chk("err_clr", bus.err_len, 0);

    // Framing error raised in the same cycle as a clear request.
    bus.in_valid = 1'b1; bus.in_data = 16'h5; bus.in_last = 1'b1; bus.err_clr = 1'b1;
    tick();
    bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.err_clr = 1'b0;
    chk("set_beats_clr", bus.err_len, 1);

    q_w = '{16'h7FFF, 16'h8000}; run_frame(-1, 0, 16'h0);
    q_w = '{16'h1111, 16'h2222}; run_frame(TIMEOUT, 1, 16'h8000);

    // Reset while waiting for the layer; its late answer must be ignored.
    rsp_dly = 20;
    rsp_data = 16'h3000;
    q_w = '{16'h4444, 16'h5555};
    send_words();
    q_w.delete();
    chk("r6_fire", bus.fire, 1);
    repeat (3) tick();
    rst = 1'b1; tick();
    chk("r6_ready", bus.in_ready, 0);
    chk("r6_busy", bus.busy, 0);
    chk("r6_vec", bus.vec_out[0], 0);
    chk("r6_res", {bus.res_valid, bus.res_data}, 0);
    rst = 1'b0;
    begin
      logic seen;
      seen = 1'b0;
      repeat (30) begin tick(); seen |= bus.res_valid | bus.busy; end
      chk("r6_late_done", seen, 0);
    end

    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 9);
      n = (kind < 7) ? NUM : (kind < 8) ? $urandom_range(1, NUM - 1) : NUM + $urandom_range(1, 3);
      for (int i = 0; i < n; i++) q_w.push_back(N'($urandom_range(0, 65535)));
      r = $urandom_range(0, 9);
      dly = (r == 0) ? -1 : (r == 1) ? TIMEOUT : $urandom_range(1, 8);
      r = $urandom_range(0, 5);
      ld = (r == 0) ? 16'h1000 : (r == 1) ? 16'h0FFF : (r == 2) ? 16'h8000 : N'($urandom_range(0, 65535));
      hold = $urandom_range(0, 3);
      run_frame(dly, hold, ld);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
